// File: rtl/bcd_score_accumulator.sv
// Brick-breaker score unit: game event codes become queued BCD addends that a digit-serial adder
// folds into a saturating score, one digit per cycle; also tracks the session high score.
module bcd_score_accumulator #(
  parameter int DIGITS     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int PTS_BRICK  = 5,
  parameter int PTS_HARD   = 20,
  parameter int PTS_COIN   = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          event_code,
  input  logic                new_game,
  output logic [4*DIGITS-1:0] score,
  output logic [4*DIGITS-1:0] high_score,
  output logic                busy,
  output logic                saturated,
  output logic                event_dropped
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(DIGITS);

  function automatic logic [W-1:0] to_bcd(input int value);
    int v;
    logic [W-1:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] BCD_BRICK = to_bcd(PTS_BRICK);
  localparam logic [W-1:0] BCD_HARD  = to_bcd(PTS_HARD);
  localparam logic [W-1:0] BCD_COIN  = to_bcd(PTS_COIN);
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic {IDLE, ADD} state_t;

  typedef struct packed {
    logic [2:0] code;
    logic [3:0] rnd;
  } entry_t;

  entry_t         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [3:0]     rnd;
  state_t         state;
  logic [W-1:0]   work, addend;
  logic           carry;
  logic [IW-1:0]  idx;
  logic           commit_pend;

  logic           valid_event, full, push, pop;
  logic [4:0]     dsum, corr;
  logic [3:0]     dnext;
  logic           dcarry;
  logic [W-1:0]   shifted;

  // Mystery box is worth ten times the random value captured when the event was queued.
  function automatic logic [W-1:0] addend_of(input entry_t e);
    logic [W-1:0] r;
    r = '0;
    case (e.code)
      3'd1:    r = BCD_BRICK;
      3'd2:    r[7:4] = e.rnd;
      3'd3:    r = BCD_HARD;
      default: r = BCD_COIN;
    endcase
    return r;
  endfunction

  assign valid_event = (event_code >= 3'd1) && (event_code <= 3'd4);
  assign full        = (count == CW'(FIFO_DEPTH));
  assign push        = valid_event && !full && !new_game;
  assign pop         = (state == IDLE) && (count != '0);
  assign busy        = (state != IDLE) || (count != '0);

  assign dsum    = {1'b0, work[3:0]} + {1'b0, addend[3:0]} + {4'b0, carry};
  assign corr    = dsum + 5'd6;
  assign dcarry  = (dsum > 5'd9);
  assign dnext   = dcarry ? corr[3:0] : dsum[3:0];
  assign shifted = {dnext, work[W-1:4]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rnd <= 4'd2;
    else       rnd <= (rnd == 4'd9) ? 4'd2 : rnd + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{code: event_code, rnd: rnd};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      event_dropped <= 1'b0;
    end else if (new_game) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      event_dropped <= 1'b0;
    end else begin
      event_dropped <= valid_event && full;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The working register rotates right one digit per cycle, so after DIGITS steps it holds the
  // full sum in order and can be committed to score in a single edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      score       <= '0;
      saturated   <= 1'b0;
      work        <= '0;
      addend      <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      commit_pend <= 1'b0;
    end else if (new_game) begin
      state       <= IDLE;
      score       <= '0;
      saturated   <= 1'b0;
      carry       <= 1'b0;
      idx         <= '0;
      commit_pend <= 1'b0;
    end else begin
      commit_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            addend <= addend_of(fifo_mem[rd_ptr]);
            work   <= score;
            carry  <= 1'b0;
            idx    <= '0;
            state  <= ADD;
          end
        end
        ADD: begin
          work   <= shifted;
          addend <= addend >> 4;
          carry  <= dcarry;
          idx    <= idx + IW'(1);
          if (idx == IW'(DIGITS - 1)) begin
            state       <= IDLE;
            commit_pend <= 1'b1;
            if (dcarry) begin
              score     <= ALL_NINES;
              saturated <= 1'b1;
            end else begin
              score <= shifted;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid BCD orders the same as plain binary, so a vector compare is an MSD-first compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   high_score <= '0;
    else if (commit_pend && (score > high_score)) high_score <= score;
  end

endmodule

// File: tb/tb_bcd_score_accumulator.sv
// Bench for bcd_score_accumulator: integer reference model feeds timestamped expectations to a
// monitor that checks every score / high_score change and every drop pulse.
module tb_bcd_score_accumulator;

  localparam int D = 4, DEPTH = 4, PB = 5, PH = 20, PC = 100, MAXV = 9999;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  event_code = 3'd0;
  logic        new_game = 1'b0;
  logic [15:0] score, high_score;
  logic        busy, saturated, event_dropped;

  bcd_score_accumulator #(
    .DIGITS(D), .FIFO_DEPTH(DEPTH), .PTS_BRICK(PB), .PTS_HARD(PH), .PTS_COIN(PC)
  ) dut (
    .clk(clk), .reset(reset), .event_code(event_code), .new_game(new_game),
    .score(score), .high_score(high_score), .busy(busy),
    .saturated(saturated), .event_dropped(event_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int at;
  } exp_t;

  int   checks = 0, errors = 0;
  exp_t sq[$], hq[$];
  int   dq[$];
  int   q[$];
  int   m_score, m_hs, m_rand, free_edge, t_next;
  bit   m_sat, pend_v, pend_sat;
  int   pend_edge, pend_val;

  bit          mon_en = 1'b0;
  int          mon_edge = 0;
  logic [15:0] last_score, last_hs;
  exp_t        me;
  int          md;

  function automatic logic [15:0] bcd(input int value);
    int v;
    logic [15:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int pts(input logic [2:0] code, input int rnd);
    case (code)
      3'd1:    return PB;
      3'd2:    return 10 * rnd;
      3'd3:    return PH;
      default: return PC;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_score = 0; m_hs = 0; m_rand = 2; free_edge = 0; t_next = 0;
    m_sat = 0; pend_v = 0; pend_sat = 0;
    q.delete(); sq.delete(); hq.delete(); dq.delete();
  endtask

  // One clock edge of the game rules, in plain integer arithmetic.
  task automatic model_step(input logic [2:0] code, input bit ng);
    int  t;
    bit  is_full;
    t = t_next;
    if (ng) begin
      pend_v = 0;
      q.delete();
      if (m_score != 0) sq.push_back('{0, t});
      m_score = 0;
      m_sat = 0;
      free_edge = t + 1;
    end else begin
      if (pend_v && pend_edge == t) begin
        if (pend_val != m_score) sq.push_back('{pend_val, t});
        m_score = pend_val;
        m_sat = pend_sat;
        if (pend_val > m_hs) begin
          m_hs = pend_val;
          hq.push_back('{pend_val, t + 1});
        end
        pend_v = 0;
      end
      is_full = (q.size() >= DEPTH);
      if (t >= free_edge && q.size() > 0) begin
        int s;
        s = m_score + q.pop_front();
        pend_sat = m_sat;
        if (s > MAXV) begin
          s = MAXV;
          pend_sat = 1;
        end
        pend_v = 1;
        pend_val = s;
        pend_edge = t + D;
        free_edge = t + D + 1;
      end
      if (code >= 3'd1 && code <= 3'd4) begin
        if (is_full) dq.push_back(t);
        else         q.push_back(pts(code, m_rand));
      end
    end
    m_rand = (m_rand == 9) ? 2 : m_rand + 1;
    t_next++;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cyc(input logic [2:0] code, input bit ng);
    event_code = code;
    new_game = ng;
    model_step(code, ng);
    @(posedge clk);
    #1;
    check("busy", busy, (pend_v || q.size() != 0));
    @(negedge clk);
  endtask

  task automatic settle();
    int n;
    n = 0;
    while ((pend_v || q.size() != 0) && n < 200) begin
      cyc(3'd0, 1'b0);
      n++;
    end
    cyc(3'd0, 1'b0);
    cyc(3'd0, 1'b0);
    check("settle_bound", (n < 200), 1);
    check("score_settled", score, bcd(m_score));
    check("hs_settled", high_score, bcd(m_hs));
    check("sat_settled", saturated, m_sat);
    check("score_q_empty", sq.size(), 0);
    check("hs_q_empty", hq.size(), 0);
    check("drop_q_empty", dq.size(), 0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_score", score, 16'h0000);
    check("rst_hs", high_score, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_sat", saturated, 1'b0);
    check("rst_drop", event_dropped, 1'b0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    event_code = 3'd0;
    new_game = 1'b0;
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (!mon_en) begin
      mon_edge = 0;
      last_score = score;
      last_hs = high_score;
    end else begin
      if (score !== last_score) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL score_unexpected: got %h expected no change at edge %0d", score, mon_edge);
        end else begin
          me = sq.pop_front();
          check("score_val", score, bcd(me.val));
          check("score_edge", mon_edge, me.at);
        end
        last_score = score;
      end
      if (high_score !== last_hs) begin
        if (hq.size() == 0) begin
          checks++; errors++;
          $display("FAIL hs_unexpected: got %h expected no change at edge %0d", high_score, mon_edge);
        end else begin
          me = hq.pop_front();
          check("hs_val", high_score, bcd(me.val));
          check("hs_edge", mon_edge, me.at);
        end
        last_hs = high_score;
      end
      if (event_dropped) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL drop_unexpected: got pulse expected none at edge %0d", mon_edge);
        end else begin
          md = dq.pop_front();
          check("drop_edge", mon_edge, md);
        end
      end
      mon_edge++;
    end
  end

  initial begin
    @(negedge clk);
    do_reset();

    // single brick
    cyc(3'd1, 1'b0);
    settle();
    check("single_brick", score, 16'h0005);

    // two bricks back to back, carry into the tens digit
    cyc(3'd0, 1'b1);
    cyc(3'd1, 1'b0);
    cyc(3'd1, 1'b0);
    settle();
    check("two_bricks", score, 16'h0010);

    // six bricks overflow the queue once
    cyc(3'd0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(3'd1, 1'b0);
    settle();
    check("six_bricks", score, 16'h0025);

    // mystery box values tied to the random counter
    cyc(3'd0, 1'b1);
    while (m_rand != 7) cyc(3'd0, 1'b0);
    cyc(3'd2, 1'b0);
    settle();
    check("mystery_7", score, 16'h0070);
    while (m_rand != 9) cyc(3'd0, 1'b0);
    cyc(3'd2, 1'b0);
    cyc(3'd2, 1'b0);
    settle();
    check("mystery_9_2", score, 16'h0180);

    // preload 9995, then saturate
    cyc(3'd0, 1'b1);
    for (int i = 0; i < 106; i++) begin
      cyc((i < 99) ? 3'd4 : (i < 103) ? 3'd3 : 3'd1, 1'b0);
      for (int j = 0; j < D; j++) cyc(3'd0, 1'b0);
    end
    settle();
    check("preload", score, 16'h9995);
    cyc(3'd3, 1'b0);
    settle();
    check("saturate_score", score, 16'h9999);
    check("saturate_flag", saturated, 1'b1);
    cyc(3'd1, 1'b0);
    settle();
    check("stay_saturated", score, 16'h9999);

    // randomized traffic including reserved codes and occasional new_game
    cyc(3'd0, 1'b1);
    for (int i = 0; i < 600; i++)
      cyc(3'($urandom_range(0, 7)), ($urandom_range(0, 49) == 0));
    settle();

    // new_game while adding with two events pending
    do_reset();
    cyc(3'd4, 1'b0);
    settle();
    check("pre_abort_score", score, 16'h0100);
    cyc(3'd1, 1'b0);
    cyc(3'd1, 1'b0);
    cyc(3'd1, 1'b0);
    cyc(3'd0, 1'b1);
    check("abort_score", score, 16'h0000);
    check("abort_busy", busy, 1'b0);
    check("abort_sat", saturated, 1'b0);
    check("abort_hs", high_score, 16'h0100);
    settle();

    // asynchronous reset in the middle of an add
    cyc(3'd1, 1'b0);
    cyc(3'd0, 1'b0);
    cyc(3'd0, 1'b0);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_score_accumulator.md
# bcd_score_accumulator

Parametrised score unit for the brick-breaker game. It converts per-cycle game event codes into BCD point additions and queues them in a small FIFO so bursts of simultaneous hits are never lost silently. A digit-serial BCD adder applies each queued event. The block drives a saturating N-digit score and a session high-score to the seven-segment and score-display logic, and sits between the collision/brick logic and the display drivers.

## Interface
- DIGITS, 4, number of BCD digits in score and high_score (2..8)
- FIFO_DEPTH, 4, pending-event queue depth (power of 2, >=2)
- PTS_BRICK, 5, points for code 1 (must be < 10^DIGITS)
- PTS_HARD, 20, points for code 3
- PTS_COIN, 100, points for code 4
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- event_code  in  3  0 none, 1 brick, 2 mystery box, 3 hard brick, 4 coin, 5-7 reserved (ignored, never queued)
- new_game  in  1  synchronous clear of score/queue/flags; high_score kept
- score  out  4*DIGITS  committed BCD score, digit 0 in bits [3:0]
- high_score  out  4*DIGITS  highest committed score since reset
- busy  out  1  adder active or queue non-empty
- saturated  out  1  sticky: score clamped at all-9s
- event_dropped  out  1  one-cycle pulse: valid event arrived with queue full

## Operation
- Reset (async, immediate): score=0, high_score=0, queue empty, FSM IDLE, saturated=0, event_dropped=0, busy=0, rand=2.
- rand: free-running 4-bit counter, 2,3,...,9,2,... advancing every clock.
- Push: valid code (1-4) with count<FIFO_DEPTH stores {code, rand} at that edge. Full test uses registered count only; a same-edge pop does not free space. Full -> entry discarded, event_dropped=1 next cycle.
- Addend per entry: code1 PTS_BRICK, code2 10*rand_stored, code3 PTS_HARD, code4 PTS_COIN. Integer parameters converted to BCD at elaboration.
- FSM IDLE: queue non-empty -> pop head, load addend, copy score into working register, carry=0, digit index=0, go ADD.
- FSM ADD: one digit per cycle, LSB first. sum=w[i]+a[i]+carry; sum>9 -> digit=sum-10 (i.e. +6 correction, 4 LSBs), carry=1; else carry=0.
- Last digit: if final carry=1, commit all-9s and set saturated; otherwise commit working register. Commit is atomic: score never shows partial sums. Return to IDLE.
- Once saturated, further events are still queued and processed; score remains all-9s.
- high_score: the cycle after any commit, if score > high_score (BCD compare, MSD first), high_score<=score.
- new_game (priority over everything except reset): score=0, queue flushed, FSM->IDLE aborting any add with no commit, saturated=0, rand unaffected. An event on the same edge is discarded without an event_dropped pulse.
- busy = (FSM!=IDLE) | (count!=0).

## Timing
- Event sampled at edge k -> queued after k; pop at edge k+1 (if IDLE); digits at edges k+2..k+1+DIGITS; score valid after edge k+1+DIGITS (5 cycles for DIGITS=4). high_score follows one cycle later.
- Throughput: one event per DIGITS+1 cycles; back-to-back pop allowed on the edge after commit (IDLE lasts one cycle).
- event_dropped is registered, asserted exactly the cycle after the rejected edge.

## Test plan
- Reset, single code1 at edge 0 -> score=0x0005 after edge 5, high_score=0x0005 after edge 6, busy low after edge 5.
- Two code1 at consecutive edges -> score 0x0005 then 0x0010 (carry across digit) after edge 10; no drop.
- Code1 on six consecutive edges (DIGITS=4, depth 4) -> one event_dropped pulse after 6th edge; final score 0x0025.
- Code2 issued when rand=7 -> score +0x0070; issued at rand=9 then rand=2 sequence -> +0x0090 then +0x0020.
- Preload to 0x9995 via events, then code3 -> score=0x9999, saturated=1; further code1 -> score stays 0x9999.
- new_game asserted mid-ADD with score 0x0100 and two queued events -> score=0, busy=0, saturated=0 next cycle, high_score unchanged at 0x0100; reset mid-ADD -> all outputs 0 immediately.
